// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Board-level startup controller for the VGA design. It waits for the
//   pixel-clock MMCM to hold lock for a stable window, keeps the core in
//   reset for a power-on window, then enables the I/O drivers, and finally
//   releases the video timing/pixel pipeline. Losing lock re-runs the
//   whole sequence from WAIT_LOCK.
//
// Ports
//   clk           in   1  system clock, rising edge
//   rst           in   1  synchronous active-high reset, overrides everything
//   pll_locked    in   1  MMCM lock (asynchronous to clk)
//   rst_core_o    out  1  active-high reset to core logic
//   rst_video_o   out  1  active-high reset to VGA timing/pixel pipeline
//   io_en_o       out  1  1 = output drivers enabled
//   ready_o       out  1  1 = sequence complete
//   state_o       out  3  current FSM state code (debug)
//   relock_cnt_o  out  8  saturating count of lock losses since rst
module reset_sequencer #(
    parameter int LOCK_STABLE = 256,
    parameter int ROC_CYCLES  = 10000,
    parameter int VID_DELAY   = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       rst_core_o,
    output logic       rst_video_o,
    output logic       io_en_o,
    output logic       ready_o,
    output logic [2:0] state_o,
    output logic [7:0] relock_cnt_o
);

    localparam int MAX_AB  = (LOCK_STABLE > ROC_CYCLES) ? LOCK_STABLE : ROC_CYCLES;
    localparam int MAX_CNT = (MAX_AB > VID_DELAY) ? MAX_AB : VID_DELAY;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] ROC_LAST  = CW'(ROC_CYCLES - 1);
    localparam logic [CW-1:0] VID_LAST  = CW'(VID_DELAY - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        ST_RESET      = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_HOLD       = 3'd2,
        ST_VIDEO_WAIT = 3'd3,
        ST_RUN        = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      relock_q, relock_d;
    logic [1:0]      sync_q;
    logic            lock_s;

    assign lock_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            state_q  <= ST_RESET;
            cnt_q    <= '0;
            relock_q <= '0;
        end else begin
            sync_q   <= {sync_q[0], pll_locked};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            relock_q <= relock_d;
        end
    end

    // Lock loss is checked before count completion in every locked-phase
    // state, so a loss on the terminal count still returns to WAIT_LOCK.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        relock_d = relock_q;
        case (state_q)
            ST_RESET: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
            ST_WAIT_LOCK: begin
                if (!lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HOLD, ST_VIDEO_WAIT, ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                    if (relock_q != '1) begin
                        relock_d = relock_q + 8'd1;
                    end
                end else if (state_q == ST_HOLD) begin
                    if (cnt_q == ROC_LAST) begin
                        state_d = ST_VIDEO_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if (state_q == ST_VIDEO_WAIT) begin
                    if (cnt_q == VID_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            // Illegal codes recover exactly like RESET.
            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Moore outputs decoded straight from the state register.
    always_comb begin
        rst_core_o  = 1'b1;
        rst_video_o = 1'b1;
        io_en_o     = 1'b0;
        ready_o     = 1'b0;
        case (state_q)
            ST_VIDEO_WAIT: begin
                rst_core_o = 1'b0;
                io_en_o    = 1'b1;
            end
            ST_RUN: begin
                rst_core_o  = 1'b0;
                rst_video_o = 1'b0;
                io_en_o     = 1'b1;
                ready_o     = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o      = state_q;
    assign relock_cnt_o = relock_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Stimulus schedules expected output vectors tagged with the clock edge
//   at which they must hold; a monitor on the falling edge pops and
//   compares them. Parameters: LOCK_STABLE=4, ROC_CYCLES=8, VID_DELAY=3.
module tb_reset_sequencer;

    logic       clk;
    logic       rst;
    logic       pll_locked;
    logic       rst_core_o;
    logic       rst_video_o;
    logic       io_en_o;
    logic       ready_o;
    logic [2:0] state_o;
    logic [7:0] relock_cnt_o;

    reset_sequencer #(
        .LOCK_STABLE (4),
        .ROC_CYCLES  (8),
        .VID_DELAY   (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .rst_core_o   (rst_core_o),
        .rst_video_o  (rst_video_o),
        .io_en_o      (io_en_o),
        .ready_o      (ready_o),
        .state_o      (state_o),
        .relock_cnt_o (relock_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [2:0] st;
        logic       rc;
        logic       rv;
        logic       io;
        logic       rdy;
        logic [7:0] rl;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Expected output row per state code, straight from the output table.
    task automatic expect_state(input int at, input logic [2:0] st,
                                input logic [7:0] rl, input string name);
        exp_t e;
        e.at = at; e.st = st; e.rl = rl; e.name = name;
        e.rc = 1'b1; e.rv = 1'b1; e.io = 1'b0; e.rdy = 1'b0;
        if (st == 3'd3) begin
            e.rc = 1'b0; e.io = 1'b1;
        end else if (st == 3'd4) begin
            e.rc = 1'b0; e.rv = 1'b0; e.io = 1'b1; e.rdy = 1'b1;
        end
        sb.push_back(e);
    endtask

    exp_t        mon_e;
    logic [14:0] mon_got;
    logic [14:0] mon_want;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            mon_e    = sb.pop_front();
            mon_got  = {state_o, rst_core_o, rst_video_o, io_en_o, ready_o, relock_cnt_o};
            mon_want = {mon_e.st, mon_e.rc, mon_e.rv, mon_e.io, mon_e.rdy, mon_e.rl};
            n_cmp++;
            if (mon_e.at != cyc || mon_got !== mon_want) begin
                n_err++;
                $display("FAIL %s @edge %0d (due %0d): got st=%0d rc=%b rv=%b io=%b rdy=%b rl=%0d, want st=%0d rc=%b rv=%b io=%b rdy=%b rl=%0d",
                         mon_e.name, cyc, mon_e.at, state_o, rst_core_o, rst_video_o,
                         io_en_o, ready_o, relock_cnt_o, mon_e.st, mon_e.rc, mon_e.rv,
                         mon_e.io, mon_e.rdy, mon_e.rl);
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Assert rst now for 'hold' edges, release, and schedule the startup
    // expectations. r0 is the first edge that samples rst=0.
    task automatic do_reset(input int hold, input bit locked);
        int c;
        int r0;
        c  = cyc;
        rst = 1'b1;
        expect_state(c + 1, 3'd0, 8'd0, "rst_state");
        wait_cyc(c + hold);
        rst = 1'b0;
        r0 = c + hold + 1;
        if (locked) begin
            expect_state(r0,      3'd1, 8'd0, "start_wait");
            expect_state(r0 + 4,  3'd1, 8'd0, "wait_lock_end");
            expect_state(r0 + 5,  3'd2, 8'd0, "hold_entry");
            expect_state(r0 + 12, 3'd2, 8'd0, "core_held");
            expect_state(r0 + 13, 3'd3, 8'd0, "core_release");
            expect_state(r0 + 15, 3'd3, 8'd0, "video_held");
            expect_state(r0 + 16, 3'd4, 8'd0, "ready");
            wait_cyc(r0 + 17);
        end else begin
            expect_state(r0,       3'd1, 8'd0, "nolock_wait0");
            expect_state(r0 + 20,  3'd1, 8'd0, "nolock_wait20");
            expect_state(r0 + 200, 3'd1, 8'd0, "nolock_wait200");
            wait_cyc(r0 + 201);
        end
    endtask

    initial begin
        int c;
        int d;
        int s;
        int k;
        int guard;
        rst = 1'b1;
        pll_locked = 1'b1;
        @(negedge clk);

        // Power-on with lock present throughout.
        do_reset(5, 1'b1);

        // One-cycle lock drop in RUN, then full resequence.
        c = cyc;
        pll_locked = 1'b0;
        expect_state(c + 2,  3'd4, 8'd0, "run_before_loss");
        expect_state(c + 3,  3'd1, 8'd1, "loss_to_wait");
        expect_state(c + 6,  3'd1, 8'd1, "relock_wait");
        expect_state(c + 7,  3'd2, 8'd1, "relock_hold");
        expect_state(c + 14, 3'd2, 8'd1, "relock_core_held");
        expect_state(c + 15, 3'd3, 8'd1, "relock_core_rel");
        expect_state(c + 17, 3'd3, 8'd1, "relock_video_held");
        expect_state(c + 18, 3'd4, 8'd1, "relock_run");
        wait_cyc(c + 1);
        pll_locked = 1'b1;
        wait_cyc(c + 19);

        // Lock drop, then a glitch (1,1,1,0,1...) while in WAIT_LOCK.
        c = cyc;
        d = c + 11;
        pll_locked = 1'b0;
        expect_state(c + 3,  3'd1, 8'd2, "glitch_enter_wait");
        expect_state(c + 7,  3'd1, 8'd2, "glitch_restart");
        expect_state(c + 10, 3'd1, 8'd2, "glitch_wait_end");
        expect_state(c + 11, 3'd2, 8'd2, "glitch_hold");
        expect_state(d + 8,  3'd3, 8'd2, "vw_entry");
        expect_state(d + 9,  3'd3, 8'd2, "vw_before_rst");
        wait_cyc(c + 1);
        pll_locked = 1'b1;
        wait_cyc(c + 4);
        pll_locked = 1'b0;
        wait_cyc(c + 5);
        pll_locked = 1'b1;

        // rst asserted during VIDEO_WAIT clears everything, then restart.
        wait_cyc(d + 9);
        do_reset(2, 1'b1);

        // 300 lock-loss events; one loss every 10 cycles.
        s = cyc;
        expect_state(s + 3,  3'd1, 8'd1, "loss_1");
        expect_state(s + 12, 3'd2, 8'd1, "hold_between_losses");
        k = 200; expect_state(s + 3 + 10 * (k - 1), 3'd1, 8'd200, "loss_200");
        k = 255; expect_state(s + 3 + 10 * (k - 1), 3'd1, 8'd255, "loss_255");
        k = 256; expect_state(s + 3 + 10 * (k - 1), 3'd1, 8'd255, "loss_256_sat");
        k = 300; expect_state(s + 3 + 10 * (k - 1), 3'd1, 8'd255, "loss_300_sat");
        expect_state(s + 3008, 3'd4, 8'd255, "recover_run");
        for (int i = 0; i < 300; i++) begin
            wait_cyc(s + 10 * i);
            pll_locked = 1'b0;
            wait_cyc(s + 10 * i + 1);
            pll_locked = 1'b1;
        end
        wait_cyc(s + 3010);

        // No lock at all after rst: stays in WAIT_LOCK.
        pll_locked = 1'b0;
        do_reset(3, 1'b0);

        guard = 0;
        while (sb.size() > 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations never reached, want 0", sb.size());
            n_cmp += sb.size();
            n_err += sb.size();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
